// File: rtl/filtro_pkg.sv
// filtro_pkg: shared constants and helpers for the non-recursive filter datapath
package filtro_pkg;
  localparam int WIDTH_MUESTRA = 25;
  localparam int TAPS_DEF = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/etapa_retardo.sv
// etapa_retardo: one delay-line stage with async reset, sync clear and enable
module etapa_retardo
  import filtro_pkg::*;
#(
  parameter int Width = WIDTH_MUESTRA
) (
  input  logic             clk44kHz,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] dato_q;
  always_ff @(posedge clk44kHz or posedge reset)
    if (reset) dato_q <= '0;
    else if (clear) dato_q <= '0;
    else if (enable) dato_q <= d_i;
  assign q_o = dato_q;
endmodule

// File: rtl/linea_retardo.sv
// linea_retardo: tapped delay line with flush, saturating fill count and shift strobe
module linea_retardo
  import filtro_pkg::*;
#(
  parameter int Width = WIDTH_MUESTRA,
  parameter int Depth = TAPS_DEF,
  localparam int CntW = clog2(Depth + 1)
) (
  input  logic                   clk44kHz,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [Width-1:0]       datoIn,
  output logic [Width*Depth-1:0] taps,
  output logic [Width-1:0]       datoOut,
  output logic [CntW-1:0]        cuenta,
  output logic                   lleno,
  output logic                   valido
);
  // slot 0 carries datoIn, slot k+1 is the output of stage k
  logic [Width*(Depth+1)-1:0] cadena;
  logic [CntW-1:0] cuenta_q, cuenta_d;
  logic valido_q, valido_d;
  assign cadena[Width-1:0] = datoIn;
  for (genvar k = 0; k < Depth; k++) begin : g_etapa
    etapa_retardo #(.Width(Width)) u_etapa (
      .clk44kHz(clk44kHz),
      .reset(reset),
      .clear(clear),
      .enable(enable),
      .d_i(cadena[k*Width +: Width]),
      .q_o(cadena[(k+1)*Width +: Width])
    );
  end
  always_comb begin
    cuenta_d = clear ? '0 : (enable && !lleno) ? cuenta_q + CntW'(1) : cuenta_q;
    valido_d = enable && !clear;
  end
  always_ff @(posedge clk44kHz or posedge reset)
    if (reset) begin
      cuenta_q <= '0;
      valido_q <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      valido_q <= valido_d;
    end
  assign taps = cadena[Width*(Depth+1)-1:Width];
  assign datoOut = cadena[Depth*Width +: Width];
  assign lleno = cuenta_q == CntW'(Depth);
  assign cuenta = cuenta_q;
  assign valido = valido_q;
endmodule

// File: tb/tb_linea_retardo.sv
// tb_linea_retardo: scoreboard-driven directed bench for linea_retardo (8x25 and 2x4)
module tb_linea_retardo;
  logic clk44kHz = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0, clear = 1'b0;
  logic [24:0] datoIn = '0;
  logic [199:0] taps;
  logic [24:0] datoOut;
  logic [3:0] cuenta;
  logic lleno, valido;
  logic enable2 = 1'b0, clear2 = 1'b0;
  logic [3:0] datoIn2 = '0;
  logic [7:0] taps2;
  logic [3:0] datoOut2;
  logic [1:0] cuenta2;
  logic lleno2, valido2;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [199:0] t;
    logic [24:0] d;
    logic [3:0] c;
  } exp_t;
  exp_t sb[$];
  logic [24:0] m[8];
  int mc = 0;

  always #5 clk44kHz = ~clk44kHz;

  linea_retardo dut (
    .clk44kHz(clk44kHz), .reset(reset), .enable(enable), .clear(clear),
    .datoIn(datoIn), .taps(taps), .datoOut(datoOut), .cuenta(cuenta),
    .lleno(lleno), .valido(valido)
  );

  linea_retardo #(.Width(4), .Depth(2)) dut2 (
    .clk44kHz(clk44kHz), .reset(reset), .enable(enable2), .clear(clear2),
    .datoIn(datoIn2), .taps(taps2), .datoOut(datoOut2), .cuenta(cuenta2),
    .lleno(lleno2), .valido(valido2)
  );

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] model_taps();
    logic [199:0] t;
    for (int k = 0; k < 8; k++) t[k*25 +: 25] = m[k];
    return t;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) m[k] = '0;
    mc = 0;
  endtask

  // drive one cycle, advance the model, then check after the edge
  task automatic tick(input logic en, input logic clr, input logic [24:0] d);
    exp_t e;
    enable = en; clear = clr; datoIn = d;
    if (clr) model_clear();
    else if (en) begin
      for (int k = 7; k > 0; k--) m[k] = m[k-1];
      m[0] = d;
      mc = (mc < 8) ? mc + 1 : 8;
      e.t = model_taps(); e.d = m[7]; e.c = 4'(mc);
      sb.push_back(e);
    end
    @(posedge clk44kHz);
    #1;
    enable = 1'b0; clear = 1'b0;
    chk("valido", {199'd0, valido}, {199'd0, en && !clr});
    chk("hold_taps", taps, model_taps());
    chk("lleno", {199'd0, lleno}, {199'd0, mc == 8});
    if (valido) begin
      if (sb.size() == 0) chk("sb_empty", 200'd1, 200'd0);
      else begin
        e = sb.pop_front();
        chk("sb_taps", taps, e.t);
        chk("sb_datoOut", {175'd0, datoOut}, {175'd0, e.d});
        chk("sb_cuenta", {196'd0, cuenta}, {196'd0, e.c});
      end
    end else chk("cuenta", {196'd0, cuenta}, 200'(mc));
  endtask

  task automatic tick2(input logic [3:0] d);
    enable2 = 1'b1; datoIn2 = d;
    @(posedge clk44kHz);
    #1;
    enable2 = 1'b0;
  endtask

  initial begin
    model_clear();
    #12;
    chk("rst_taps", taps, 200'd0);
    chk("rst_out", {172'd0, datoOut, cuenta, lleno, valido}, 200'd0);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) tick(1'b1, 1'b0, 25'(i));
    chk("fill_s0", {175'd0, taps[24:0]}, 200'd8);
    chk("fill_s7", {175'd0, taps[199:175]}, 200'd1);
    chk("fill_out", {175'd0, datoOut}, 200'd1);
    chk("fill_cnt", {196'd0, cuenta}, 200'd8);
    chk("fill_lleno", {199'd0, lleno}, 200'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 25'h1FFFFFF);
      tick(1'b0, 1'b0, 25'h0ABCDEF);
      tick(1'b0, 1'b0, 25'h0123456);
    end
    chk("neg_s0", {175'd0, taps[24:0]}, 200'h1FFFFFF);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 25'(32'h00A5_0000 + i * 32'h0101_0003));
    chk("sat_cnt", {196'd0, cuenta}, 200'd8);
    chk("sat_out", {175'd0, datoOut}, 200'(25'(32'h00A5_0000 + 4 * 32'h0101_0003)));
    tick(1'b1, 1'b1, 25'h55);
    chk("clr_taps", taps, 200'd0);
    chk("clr_cnt", {195'd0, cuenta, valido}, 200'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 25'(100 + i));
    chk("pre_rst_cnt", {196'd0, cuenta}, 200'd5);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_taps", taps, 200'd0);
    chk("arst_out", {172'd0, datoOut, cuenta, lleno, valido}, 200'd0);
    model_clear();
    sb.delete();
    #1;
    reset = 1'b0;
    tick(1'b1, 1'b0, 25'd7);
    chk("post_rst_s0", {175'd0, taps[24:0]}, 200'd7);
    chk("post_rst_cnt", {196'd0, cuenta}, 200'd1);
    chk("d2_cnt0", {196'd0, 2'd0, cuenta2}, 200'd0);
    tick2(4'd3);
    chk("d2_lleno1", {199'd0, lleno2}, 200'd0);
    tick2(4'd9);
    chk("d2_lleno2", {199'd0, lleno2}, 200'd1);
    chk("d2_taps2", {192'd0, taps2}, 200'h39);
    tick2(4'd4);
    chk("d2_taps3", {192'd0, taps2}, 200'h94);
    chk("d2_out", {196'd0, datoOut2}, 200'd9);
    chk("d2_cnt", {198'd0, cuenta2}, 200'd2);
    chk("sb_drained", 200'(sb.size()), 200'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/linea_retardo.md
# linea_retardo

Parametrised tapped delay line for the non-recursive filter datapath: on each accepted sample it shifts a new `Width`-bit sample into a chain of `Depth` stages and exposes every stage in parallel to the multiply-accumulate stage. It replaces a hand-chained set of single enabled registers. It adds three things those lack: synchronous flush, a saturating fill count with a full flag, and a one-cycle valid strobe that tells downstream logic the taps have just advanced.

## Interface
- `Width`, 25, bits per sample/stage
- `Depth`, 8, number of stages (taps); legal range 2..64
- `CntW`, derived = ceil(log2(Depth+1)), width of fill counter (localparam, not overridable)

- `clk44kHz` input 1 — sample-domain clock, rising edge active
- `reset` input 1 — asynchronous, active-high; clears all state
- `enable` input 1 — sample strobe; shift occurs on the rising edge where `enable`=1
- `clear` input 1 — synchronous flush; priority over `enable`
- `datoIn` input `Width` — new sample, two's complement
- `taps` output `Width*Depth` — flattened stages; stage k at bits [k*Width +: Width], stage 0 newest
- `datoOut` output `Width` — oldest stage (stage `Depth-1`)
- `cuenta` output `CntW` — number of valid samples held, saturates at `Depth`
- `lleno` output 1 — `cuenta == Depth`
- `valido` output 1 — one-cycle pulse, registered, high the cycle after each accepted shift

## Operation
- Reset (async): all stages = 0, `cuenta` = 0, `lleno` = 0, `valido` = 0, `datoOut` = 0.
- Edge with `clear`=1 (any `enable`): all stages = 0, `cuenta` = 0, `valido` = 0; `datoIn` discarded.
- Edge with `clear`=0, `enable`=1: stage0 <= `datoIn`; stage k <= stage k-1 for k=1..Depth-1; previous stage `Depth-1` discarded; `cuenta` <= min(`cuenta`+1, `Depth`); `valido` <= 1.
- Edge with `clear`=0, `enable`=0: all stages hold; `cuenta` holds; `valido` <= 0.
- `lleno` combinational from registered `cuenta`; no extra latency.
- No arithmetic on data; samples pass bit-exact, no sign extension or truncation.
- `cuenta` never wraps: it stays at `Depth` while `enable` continues.
- `enable` held high continuously is legal: shift every edge, `valido` stays high.

## Timing
- Latency: a sample accepted at edge n is visible on stage 0 after edge n; on stage k after k further accepted edges; on `datoOut` after `Depth` accepted edges in total.
- `valido` rises after the same edge that updates the stages, so taps and `valido` are coherent in the same cycle.
- `lleno` asserts after the `Depth`-th accepted edge following reset or clear.
- Reset asserted mid-stream: outputs go to reset values immediately (asynchronous), without waiting for a clock edge. On deassertion, the first edge with `enable`=1 loads stage 0 and sets `cuenta`=1.
- Simultaneous `clear`+`enable`: the clear wins; `cuenta`=0 and `valido`=0 after that edge.

## Structure
- Shared package `filtro_pkg`: `clog2` function, default `WIDTH_MUESTRA`=25 and `TAPS_DEF`=8 constants used by the filter top and MAC.
- Sub-module `etapa_retardo`: one `Width`-bit register with async reset, sync clear, and enable. It is instantiated `Depth` times in a generate loop.
- Fill counter and `valido` flop live in `linea_retardo` itself.

## Test plan
- Reset then 8 strobes, `datoIn`=1..8 (`Depth`=8): after the 8th, stage0=8 … stage7=1, `datoOut`=1, `cuenta`=8, `lleno`=1.
- Strobe 1 cycle in 3 with `datoIn`=0x1FFFFFF (-1): taps hold between strobes, `valido` high only the cycle after each strobe, value bit-exact.
- 12 strobes after full: `cuenta` stays 8, `datoOut` tracks the sample from 8 strobes earlier, no wrap.
- `clear`=1 with `enable`=1, `datoIn`=0x55: all taps 0, `cuenta`=0, `valido`=0, 0x55 not loaded.
- Assert `reset` between clock edges mid-stream with `cuenta`=5: outputs 0 immediately. After release, one strobe with `datoIn`=7 gives stage0=7 and `cuenta`=1.
- `Depth`=2, `Width`=4: strobes 3, 9, 4 give taps {stage1=9, stage0=4}, `lleno`=1 after the 2nd strobe.
